// File: rtl/adc_emul_pkg.sv
// ADC emulator shared definitions.
// Pattern mode codes and sequencer FSM state encodings.
package adc_emul_pkg;

  localparam logic [1:0] MODE_TRI   = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/adc_emul_if.sv
// ADC emulator control/sample bundle.
// master: board registers + LVDS stage; slave: adc_emul_ctrl.
interface adc_emul_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic [1:0]         cfg_mode;
  logic [WIDTH-1:0]   cfg_step;
  logic [WIDTH-1:0]   cfg_lo;
  logic [WIDTH-1:0]   cfg_hi;
  logic [CNT_W-1:0]   cfg_len;
  logic               start;
  logic               stop;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic               frame_clk;
  logic               samp_valid;
  logic [WIDTH-1:0]   samp_p;
  logic [WIDTH-1:0]   samp_n;
  logic [2*WIDTH-1:0] lvds;

  modport master (
    output cfg_mode, cfg_step, cfg_lo, cfg_hi, cfg_len,
    output start, stop,
    input  busy, done, cfg_err, frame_clk, samp_valid,
    input  samp_p, samp_n, lvds
  );

  modport slave (
    input  cfg_mode, cfg_step, cfg_lo, cfg_hi, cfg_len,
    input  start, stop,
    output busy, done, cfg_err, frame_clk, samp_valid,
    output samp_p, samp_n, lvds
  );
endinterface

// File: rtl/adc_emul_patgen.sv
// Pattern accumulator: load -> acc=lo, advance -> next value per mode.
// In: clk, reset, load, advance, mode, step, lo, hi. Out: acc.
module adc_emul_patgen
  import adc_emul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] acc
);

  logic             dir_dn;
  logic             dir_nx;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH:0]   stp;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   lo_st;

  // one extra bit so bound tests never wrap
  assign stp   = (step == '0) ? {{WIDTH{1'b0}}, 1'b1}
                              : {1'b0, step};
  assign sum   = {1'b0, acc} + stp;
  assign lo_st = {1'b0, lo} + stp;

  always_comb begin
    acc_nx = acc;
    dir_nx = dir_dn;
    unique case (1'b1)
      (mode == MODE_TRI): begin
        if (!dir_dn) begin
          if (sum > {1'b0, hi}) begin
            acc_nx = hi;
            dir_nx = 1'b1;
          end else begin
            acc_nx = sum[WIDTH-1:0];
          end
        end else if ({1'b0, acc} < lo_st) begin
          acc_nx = lo;
          dir_nx = 1'b0;
        end else begin
          acc_nx = acc - stp[WIDTH-1:0];
        end
      end
      (mode == MODE_RAMP):
        acc_nx = (sum > {1'b0, hi}) ? lo : sum[WIDTH-1:0];
      (mode == MODE_CONST):
        acc_nx = hi;
      (mode == MODE_ALT):
        acc_nx = (acc == lo) ? hi : lo;
      default: acc_nx = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      dir_dn <= 1'b0;
    end else if (load) begin
      acc    <= lo;
      dir_dn <= 1'b0;
    end else if (advance) begin
      acc    <= acc_nx;
      dir_dn <= dir_nx;
    end
  end

endmodule

// File: rtl/adc_emul_ctrl.sv
// ADC emulator sequencer: FSM, p/n phase, burst counter, sample regs.
// Ports: clk, reset (async active-low), bus (adc_emul_if.slave).
module adc_emul_ctrl
  import adc_emul_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       reset,
  adc_emul_if.slave bus
);

  logic [1:0]       state;
  logic             ph;
  logic             stop_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [CNT_W-1:0] len_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] samp_p;
  logic [WIDTH-1:0] samp_n;
  logic             done;
  logic             cfg_err;
  logic             frame_clk;
  logic             samp_valid;
  logic             last_pair;

  adc_emul_patgen #(.WIDTH(WIDTH)) u_patgen (
    .clk     (clk),
    .reset   (reset),
    .load    (state == ST_ARM),
    .advance (state == ST_RUN),
    .mode    (mode_q),
    .step    (step_q),
    .lo      (lo_q),
    .hi      (hi_q),
    .acc     (acc)
  );

  // stop in the closing cycle still counts as seen
  assign last_pair = ((len_q != '0) && (cnt == CNT_W'(1)))
                   || stop_q || bus.stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ph         <= 1'b0;
      stop_q     <= 1'b0;
      cnt        <= '0;
      mode_q     <= '0;
      step_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      samp_p     <= '0;
      samp_n     <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      frame_clk  <= 1'b0;
      samp_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (bus.start) begin
            if (bus.cfg_lo <= bus.cfg_hi) begin
              mode_q  <= bus.cfg_mode;
              step_q  <= bus.cfg_step;
              lo_q    <= bus.cfg_lo;
              hi_q    <= bus.cfg_hi;
              len_q   <= bus.cfg_len;
              cfg_err <= 1'b0;
              stop_q  <= 1'b0;
              state   <= ST_ARM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        (state == ST_ARM): begin
          ph    <= 1'b0;
          cnt   <= len_q;
          state <= ST_RUN;
          if (bus.stop) stop_q <= 1'b1;
        end
        (state == ST_RUN): begin
          if (bus.stop) stop_q <= 1'b1;
          ph <= ~ph;
          if (!ph) begin
            samp_p     <= acc;
            frame_clk  <= 1'b1;
            samp_valid <= 1'b1;
          end else begin
            samp_n    <= acc;
            frame_clk <= 1'b0;
            if (len_q != '0) cnt <= cnt - CNT_W'(1);
            if (last_pair) state <= ST_DONE;
          end
        end
        (state == ST_DONE): begin
          done       <= 1'b1;
          samp_valid <= 1'b0;
          frame_clk  <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done;
  assign bus.cfg_err    = cfg_err;
  assign bus.frame_clk  = frame_clk;
  assign bus.samp_valid = samp_valid;
  assign bus.samp_p     = samp_p;
  assign bus.samp_n     = samp_n;
  assign bus.lvds       = {samp_n, samp_p};

endmodule

// File: tb/tb_adc_emul_ctrl.sv
// Directed bench for adc_emul_ctrl.
// Streams captured from p/n phases are checked against fixed tables.
module tb_adc_emul_ctrl;

  logic clk;
  logic reset;

  adc_emul_if #(.WIDTH(4), .CNT_W(16)) bus ();

  adc_emul_ctrl #(.WIDTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];
  int exp_q[$];
  int first_c;
  int done_c;
  int lvds1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), q[i], exp_q[i]);
  endtask

  task automatic run_burst(input logic [1:0] mode, input int step,
                           input int lo, input int hi, input int len,
                           input int stop_pairs, input int max_cyc);
    int  npairs;
    bit  prev_fc;
    bit  stop_sent;
    q.delete();
    first_c   = -1;
    done_c    = -1;
    lvds1     = -1;
    npairs    = 0;
    prev_fc   = 1'b0;
    stop_sent = 1'b0;
    @(negedge clk);
    bus.cfg_mode = mode;
    bus.cfg_step = 4'(step);
    bus.cfg_lo   = 4'(lo);
    bus.cfg_hi   = 4'(hi);
    bus.cfg_len  = 16'(len);
    bus.start    = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (bus.samp_valid && bus.frame_clk) begin
        q.push_back(int'(bus.samp_p));
        if (first_c < 0) first_c = c;
      end
      if (prev_fc && !bus.frame_clk && bus.samp_valid) begin
        q.push_back(int'(bus.samp_n));
        npairs++;
        if (npairs == 1) lvds1 = int'(bus.lvds);
      end
      prev_fc = bus.frame_clk;
      if (bus.done) begin
        done_c = c;
        break;
      end
      if (!stop_sent && stop_pairs >= 0 && npairs == stop_pairs
          && bus.samp_valid && !bus.frame_clk) begin
        bus.stop  = 1'b1;
        stop_sent = 1'b1;
      end
    end
    bus.stop = 1'b0;
    if (done_c < 0) chk("timeout_done", 0, 1);
  endtask

  initial begin
    int  seen;
    reset        = 1'b0;
    bus.cfg_mode = '0;
    bus.cfg_step = '0;
    bus.cfg_lo   = '0;
    bus.cfg_hi   = '0;
    bus.cfg_len  = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.samp_valid), 0);
    chk("rst_lvds", int'(bus.lvds), 0);
    chk("rst_err", int'(bus.cfg_err), 0);
    @(negedge clk);
    reset = 1'b1;

    // triangle with clamp repeats at both bounds
    run_burst(2'd0, 1, 1, 14, 16, -1, 200);
    exp_q = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,14,13,
              12,11,10,9,8,7,6,5,4,3,2,1,1,2,3,4};
    cmp_stream("t1");
    chk("t1_first", first_c, 2);
    chk("t1_done_lat", done_c - first_c, 32);

    run_burst(2'd0, 5, 0, 14, 4, -1, 100);
    exp_q = '{0,5,10,14,9,4,0,5};
    cmp_stream("t2");
    chk("t2_lvds", lvds1, 'h50);

    run_burst(2'd1, 3, 2, 11, 3, -1, 100);
    exp_q = '{2,5,8,11,2,5};
    cmp_stream("t3");
    chk("t3_busy_at_done", int'(bus.busy), 0);
    @(negedge clk);
    chk("t3_done_pulse", int'(bus.done), 0);
    chk("t3_busy_after", int'(bus.busy), 0);

    // continuous alternate, stop after two pairs
    run_burst(2'd3, 1, 3, 12, 0, 2, 100);
    exp_q = '{3,12,3,12,3,12};
    cmp_stream("t4");
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.samp_valid) seen = 1;
    end
    chk("t4_no_valid", seen, 0);

    // bad bounds rejected, then recovered
    @(negedge clk);
    bus.cfg_lo = 4'd9;
    bus.cfg_hi = 4'd4;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_err", int'(bus.cfg_err), 1);
    chk("t5_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("t5_err_sticky", int'(bus.cfg_err), 1);
    run_burst(2'd3, 1, 4, 9, 1, -1, 50);
    exp_q = '{4,9};
    cmp_stream("t5");
    chk("t5_err_clr", int'(bus.cfg_err), 0);

    // lo==hi, step 0 treated as 1, const mode
    run_burst(2'd0, 0, 3, 5, 3, -1, 50);
    exp_q = '{3,4,5,5,4,3};
    cmp_stream("t7_step0");
    run_burst(2'd2, 2, 6, 6, 2, -1, 50);
    exp_q = '{6,6,6,6};
    cmp_stream("t7_lohi");
    run_burst(2'd2, 1, 2, 9, 2, -1, 50);
    exp_q = '{2,9,9,9};
    cmp_stream("t7_const");

    // start while busy ignored, then async reset
    @(negedge clk);
    bus.cfg_mode = 2'd0;
    bus.cfg_step = 4'd1;
    bus.cfg_lo   = 4'd0;
    bus.cfg_hi   = 4'd15;
    bus.cfg_len  = 16'd0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_p0", int'(bus.samp_p), 0);
    bus.cfg_mode = 2'd3;
    bus.cfg_lo   = 4'd7;
    bus.cfg_hi   = 4'd8;
    bus.cfg_len  = 16'd1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t6_n0", int'(bus.samp_n), 1);
    @(negedge clk);
    chk("t6_p1", int'(bus.samp_p), 2);
    @(negedge clk);
    chk("t6_n1", int'(bus.samp_n), 3);
    chk("t6_busy", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.samp_valid), 0);
    chk("t6_rst_fclk", int'(bus.frame_clk), 0);
    chk("t6_rst_lvds", int'(bus.lvds), 0);
    chk("t6_rst_done", int'(bus.done), 0);
    seen = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("t6_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
